peripheral_mpi_noc_buffer: RTL and testbench
============================================

PERIPHERAL_MPI_NOC_BUFFER -- requirements
Module: peripheral_mpi_noc_buffer

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32, meaning flit data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning flit storage entries (power of 2, >=2).
REQ-003 SHALL have parameter FULLPACKET, default 0, meaning 1 = present a packet only once its last flit is stored.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_flit  input  FLIT_WIDTH  incoming flit from NoC router.
REQ-007 SHALL have port in_last  input  1  incoming flit ends its packet.
REQ-008 SHALL have port in_valid  input  1  incoming flit valid.
REQ-009 SHALL have port in_ready  output  1  buffer accepts a flit this cycle.
REQ-010 SHALL have port out_flit  output  FLIT_WIDTH  head flit toward peripheral_mpi_bb noc_in_flit.
REQ-011 SHALL have port out_last  output  1  head flit ends its packet.
REQ-012 SHALL have port out_valid  output  1  head flit valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head flit.
REQ-014 SHALL have port packet_size  output  $clog2(DEPTH+1)  flits from head through first stored last flit, inclusive.

Function
REQ-015 SHALL write in_flit/in_last at the tail when in_valid && in_ready at a clock edge.
REQ-016 SHALL pop the head when out_valid && out_ready at a clock edge.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinational from registered count only; no dependence on out_ready.
REQ-018 SHALL be first-word-fall-through: a flit written into an empty buffer at edge k appears on out_flit/out_valid after edge k (1-cycle latency); no same-cycle bypass.
REQ-019 SHALL drive out_flit/out_last from the head entry; values are don't-care while out_valid=0.
REQ-020 SHALL, with FULLPACKET=0, drive out_valid = (count != 0).
REQ-021 SHALL, with FULLPACKET=1, drive out_valid = (at least one stored flit has last=1) || (count == DEPTH); the full-buffer term prevents deadlock on packets longer than DEPTH.
REQ-022 SHALL, on simultaneous write and pop, leave count unchanged and advance both pointers.
REQ-023 SHALL, when full, refuse writes (in_ready=0) even if a pop occurs that cycle.
REQ-024 SHALL, when empty, ignore out_ready.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH, width $clog2(DEPTH+1).
REQ-026 SHALL compute packet_size combinationally as 1 + distance from head to the first stored entry with last=1, scanning count entries from head; 0 when no stored last flit.
REQ-027 SHALL hold stored data stable while out_valid && !out_ready.
REQ-028 SHALL treat in_last as flit metadata only; it does not alter acceptance rules.

Reset
REQ-029 SHALL, on rst asserted, asynchronously clear read pointer, write pointer and count to 0, discarding all stored flits including partial packets.
REQ-030 SHALL hold during reset and immediately after: out_valid=0, in_ready=1, packet_size=0; out_flit/out_last = 0.
REQ-031 SHALL accept a flit on the first rising edge after rst deasserts.
REQ-032 SHALL not require storage array contents to be reset.

Verification
REQ-033 SHALL verify FWFT latency: empty, FULLPACKET=0, write 0xA5A5_0001 last=1 at edge k -> out_valid=1, out_flit=0xA5A5_0001, out_last=1, packet_size=1 after edge k; pop at k+1 -> out_valid=0.
REQ-034 SHALL verify full: out_ready=0, write 16 flits 0..15 -> in_ready=0 after 16th; 17th flit not accepted; with out_ready=1 and in_valid=1 same cycle -> one pop, no write, count=15; next cycle write accepted; output order 0..15 then 16.
REQ-035 SHALL verify FULLPACKET=1: write 3-flit packet, last on third -> out_valid=0 after flits 1-2, out_valid=1 and packet_size=3 after flit 3; then 20 flits without last -> out_valid asserts once count=16.
REQ-036 SHALL verify packet_size: store packets of lengths 2 and 4 -> packet_size=2; pop two -> packet_size=4; pop four -> 0.
REQ-037 SHALL verify reset mid-operation: 5 flits stored, rst pulsed asynchronously between edges -> out_valid=0, in_ready=1, packet_size=0 immediately; next flit written emerges as sole head.
REQ-038 SHALL verify wrap-around: 40 flits with random in_valid/out_ready throttling -> output sequence equals input sequence, no loss or duplication, in_ready never 1 when count=16.

Source files
------------

// File: rtl/peripheral_mpi_noc_buffer.sv
// Purpose : flit FIFO between a NoC router port and the MPI block, optional whole-packet release.
// Latency : 1 cycle from an accepted write to head visibility (first-word-fall-through, no bypass).
// Backpr. : in_ready drops only when all DEPTH entries are used, independent of out_ready.
//
// Ports:
//   clk, rst                      - sole clock; asynchronous active-high reset
//   in_flit/in_last/in_valid      - flit from router; written when in_valid && in_ready
//   in_ready                      - buffer has room (count < DEPTH)
//   out_flit/out_last/out_valid   - head flit toward peripheral_mpi_bb; popped when out_valid && out_ready
//   out_ready                     - consumer takes the head flit
//   packet_size                   - flits from head through the first stored last flit, 0 if none
module peripheral_mpi_noc_buffer #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FULLPACKET = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_WIDTH-1:0]        in_flit,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   packet_size
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Storage is deliberately not reset; count alone decides what is valid.
    logic [FLIT_WIDTH-1:0] flit_mem [DEPTH];
    logic [DEPTH-1:0]      last_mem;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          wr_en;
    logic          rd_en;
    logic          empty;
    logic          full;

    logic          last_found;
    logic [CW-1:0] scan_size;
    logic [AW-1:0] scan_idx;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Acceptance looks only at the registered count, so a full buffer refuses
    // a write even in a cycle where the head is being popped.
    assign in_ready = !full;
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = out_valid && out_ready;

    // Head presentation. Zero while empty so outputs are clean out of reset
    // even though the storage array holds arbitrary contents.
    assign out_flit = empty ? '0   : flit_mem[rd_ptr];
    assign out_last = empty ? 1'b0 : last_mem[rd_ptr];

    // Walk the occupied entries from the head and stop at the first one
    // marked last. Entries beyond count are stale and must be ignored.
    always_comb begin
        last_found = 1'b0;
        scan_size  = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + AW'(i);
            if (!last_found && (CW'(i) < count) && last_mem[scan_idx]) begin
                last_found = 1'b1;
                scan_size  = CW'(i + 1);
            end
        end
    end

    assign packet_size = scan_size;

    // In whole-packet mode the head is held back until a complete packet is
    // stored; a completely full buffer is released anyway so that packets
    // longer than DEPTH can still drain instead of deadlocking.
    assign out_valid = (FULLPACKET != 0) ? (last_found || full) : !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            flit_mem[wr_ptr] <= in_flit;
            last_mem[wr_ptr] <= in_last;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mpi_noc_buffer.sv
module tb_peripheral_mpi_noc_buffer;

    typedef logic [32:0] ent_t;   // {last, flit}

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_last;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0;
    logic [31:0] out_flit0;
    logic [4:0]  ps0;
    logic        in_ready1, out_valid1, out_last1;
    logic [31:0] out_flit1;
    logic [4:0]  ps1;

    int   nvec = 0;
    int   nerr = 0;
    ent_t q0[$];
    ent_t q1[$];

    always #5 clk = ~clk;

    peripheral_mpi_noc_buffer #(.FLIT_WIDTH(32), .DEPTH(16), .FULLPACKET(0)) dut (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready0),
        .out_flit(out_flit0), .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready),
        .packet_size(ps0)
    );

    peripheral_mpi_noc_buffer #(.FLIT_WIDTH(32), .DEPTH(16), .FULLPACKET(1)) dut_fp (
        .clk(clk), .rst(rst),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready1),
        .out_flit(out_flit1), .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready),
        .packet_size(ps1)
    );

    function automatic int model_ps(input ent_t q[$]);
        for (int i = 0; i < q.size(); i++)
            if (q[i][32]) return i + 1;
        return 0;
    endfunction

    // One clock: check both instances against the queue models, retire pops,
    // record accepted writes, then advance to 1 time unit after the edge.
    task automatic step();
        ent_t e;
        int   eps;
        logic exp_v;
        // plain buffer
        nvec++;
        if (in_ready0 !== (q0.size() < 16)) begin
            nerr++; $display("FAIL in_ready_fp0: got %b want %b (stored %0d)", in_ready0, q0.size() < 16, q0.size());
        end
        nvec++;
        if (out_valid0 !== (q0.size() != 0)) begin
            nerr++; $display("FAIL out_valid_fp0: got %b want %b", out_valid0, q0.size() != 0);
        end
        eps = model_ps(q0);
        nvec++;
        if (ps0 !== 5'(eps)) begin
            nerr++; $display("FAIL packet_size_fp0: got %0d want %0d", ps0, eps);
        end
        if (out_valid0 === 1'b1 && out_ready === 1'b1) begin
            nvec++;
            if (q0.size() == 0) begin
                nerr++; $display("FAIL pop_fp0: popped %h with nothing expected", out_flit0);
            end else begin
                e = q0.pop_front();
                if ({out_last0, out_flit0} !== e) begin
                    nerr++; $display("FAIL data_fp0: got %b/%h want %b/%h", out_last0, out_flit0, e[32], e[31:0]);
                end
            end
        end
        if (in_valid && in_ready0 === 1'b1) q0.push_back({in_last, in_flit});
        // whole-packet buffer
        nvec++;
        if (in_ready1 !== (q1.size() < 16)) begin
            nerr++; $display("FAIL in_ready_fp1: got %b want %b (stored %0d)", in_ready1, q1.size() < 16, q1.size());
        end
        eps   = model_ps(q1);
        exp_v = (eps != 0) || (q1.size() == 16);
        nvec++;
        if (out_valid1 !== exp_v) begin
            nerr++; $display("FAIL out_valid_fp1: got %b want %b", out_valid1, exp_v);
        end
        nvec++;
        if (ps1 !== 5'(eps)) begin
            nerr++; $display("FAIL packet_size_fp1: got %0d want %0d", ps1, eps);
        end
        if (out_valid1 === 1'b1 && out_ready === 1'b1) begin
            nvec++;
            if (q1.size() == 0) begin
                nerr++; $display("FAIL pop_fp1: popped %h with nothing expected", out_flit1);
            end else begin
                e = q1.pop_front();
                if ({out_last1, out_flit1} !== e) begin
                    nerr++; $display("FAIL data_fp1: got %b/%h want %b/%h", out_last1, out_flit1, e[32], e[31:0]);
                end
            end
        end
        if (in_valid && in_ready1 === 1'b1) q1.push_back({in_last, in_flit});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) step();
        step();
        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nerr++; $display("FAIL drain_timeout: left %0d/%0d want 0/0", q0.size(), q1.size());
        end
        out_ready = 1'b0;
    endtask

    // Hold one flit until the whole-packet instance takes it.
    task automatic send_fp(input logic [31:0] f, input logic l);
        logic acc;
        int   n;
        in_flit  = f;
        in_last  = l;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (n = 0; n < 100 && !acc; n++) begin
            acc = (in_ready1 === 1'b1);
            step();
        end
        in_valid = 1'b0;
        nvec++;
        if (!acc) begin
            nerr++; $display("FAIL send_timeout: flit %h got accepted=0 want 1", f);
        end
    endtask

    task automatic test_reset();
        nvec++; if (out_valid0 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid0: got %b want 0", out_valid0); end
        nvec++; if (out_valid1 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid1: got %b want 0", out_valid1); end
        nvec++; if (in_ready0 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready0: got %b want 1", in_ready0); end
        nvec++; if (in_ready1 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready1: got %b want 1", in_ready1); end
        nvec++; if (ps0 !== 5'd0) begin nerr++; $display("FAIL rst_psize0: got %0d want 0", ps0); end
        nvec++; if (ps1 !== 5'd0) begin nerr++; $display("FAIL rst_psize1: got %0d want 0", ps1); end
        nvec++; if (out_flit0 !== 32'h0 || out_last0 !== 1'b0) begin nerr++; $display("FAIL rst_out_flit0: got %h/%b want 0/0", out_flit0, out_last0); end
        nvec++; if (out_flit1 !== 32'h0 || out_last1 !== 1'b0) begin nerr++; $display("FAIL rst_out_flit1: got %h/%b want 0/0", out_flit1, out_last1); end
    endtask

    task automatic test_fwft();
        in_flit = 32'hA5A5_0001; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        nvec++; if (out_valid0 !== 1'b0) begin nerr++; $display("FAIL fwft_bypass: got %b want 0", out_valid0); end
        step();
        in_valid = 1'b0;
        nvec++; if (out_valid0 !== 1'b1) begin nerr++; $display("FAIL fwft_valid: got %b want 1", out_valid0); end
        nvec++; if (out_flit0 !== 32'hA5A5_0001) begin nerr++; $display("FAIL fwft_flit: got %h want a5a50001", out_flit0); end
        nvec++; if (out_last0 !== 1'b1) begin nerr++; $display("FAIL fwft_last: got %b want 1", out_last0); end
        nvec++; if (ps0 !== 5'd1) begin nerr++; $display("FAIL fwft_psize: got %0d want 1", ps0); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nvec++; if (out_valid0 !== 1'b0) begin nerr++; $display("FAIL fwft_pop: got %b want 0", out_valid0); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_flit = 32'(i); in_last = (i == 15); in_valid = 1'b1;
            step();
        end
        nvec++; if (in_ready0 !== 1'b0) begin nerr++; $display("FAIL full_in_ready: got %b want 0", in_ready0); end
        in_flit = 32'd16; in_last = 1'b1;
        step();   // refused: buffer full
        nvec++; if (q0.size() != 16) begin nerr++; $display("FAIL full_refuse: stored %0d want 16", q0.size()); end
        out_ready = 1'b1;
        step();   // pop and offered write in the same cycle: only the pop happens
        out_ready = 1'b0;
        nvec++; if (in_ready0 !== 1'b1) begin nerr++; $display("FAIL full_pop_no_write: in_ready got %b want 1", in_ready0); end
        step();   // now accepted
        in_valid = 1'b0;
        nvec++; if (in_ready0 !== 1'b0) begin nerr++; $display("FAIL full_refill: in_ready got %b want 0", in_ready0); end
        drain();
    endtask

    task automatic test_fullpacket();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_flit = 32'(100 + i); in_last = (i == 2); in_valid = 1'b1;
            step();
            nvec++;
            if (out_valid1 !== (i == 2)) begin nerr++; $display("FAIL fp_valid_%0d: got %b want %b", i, out_valid1, i == 2); end
        end
        in_valid = 1'b0;
        nvec++; if (ps1 !== 5'd3) begin nerr++; $display("FAIL fp_psize: got %0d want 3", ps1); end
        drain();
        for (int i = 0; i < 16; i++) begin
            in_flit = 32'(200 + i); in_last = 1'b0; in_valid = 1'b1;
            step();
            if (i == 14) begin
                nvec++; if (out_valid1 !== 1'b0) begin nerr++; $display("FAIL fp_partial: got %b want 0", out_valid1); end
            end
        end
        nvec++; if (out_valid1 !== 1'b1) begin nerr++; $display("FAIL fp_full_release: got %b want 1", out_valid1); end
        out_ready = 1'b1;
        for (int i = 16; i < 20; i++) send_fp(32'(200 + i), 1'b0);
        send_fp(32'h0000_02FF, 1'b1);
        drain();
    endtask

    task automatic test_packet_size();
        logic [31:0] fl [6] = '{32'd300, 32'd301, 32'd302, 32'd303, 32'd304, 32'd305};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_flit = fl[i]; in_last = (i == 1 || i == 5); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        nvec++; if (ps0 !== 5'd2) begin nerr++; $display("FAIL psize_first: got %0d want 2", ps0); end
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
        nvec++; if (ps0 !== 5'd4) begin nerr++; $display("FAIL psize_second: got %0d want 4", ps0); end
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        nvec++; if (ps0 !== 5'd0) begin nerr++; $display("FAIL psize_empty: got %0d want 0", ps0); end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_flit = 32'(400 + i); in_last = (i == 4); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b%b want 00", out_valid0, out_valid1); end
        nvec++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin nerr++; $display("FAIL midrst_ready: got %b%b want 11", in_ready0, in_ready1); end
        nvec++; if (ps0 !== 5'd0 || ps1 !== 5'd0) begin nerr++; $display("FAIL midrst_psize: got %0d/%0d want 0/0", ps0, ps1); end
        q0.delete(); q1.delete();
        #1 rst = 1'b0;
        in_flit = 32'd500; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        nvec++; if (out_valid0 !== 1'b1 || out_flit0 !== 32'd500) begin nerr++; $display("FAIL midrst_head0: got %b/%h want 1/000001f4", out_valid0, out_flit0); end
        nvec++; if (out_valid1 !== 1'b1 || out_flit1 !== 32'd500) begin nerr++; $display("FAIL midrst_head1: got %b/%h want 1/000001f4", out_valid1, out_flit1); end
        nvec++; if (ps0 !== 5'd1) begin nerr++; $display("FAIL midrst_psize_after: got %0d want 1", ps0); end
        drain();
    endtask

    task automatic test_wrap();
        int   sent = 0;
        logic acc;
        for (int n = 0; n < 2000 && sent < 40; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_flit   = 32'(1000 + sent);
            in_last   = (sent == 39) || ($urandom_range(0, 3) == 0);
            acc       = in_valid && (in_ready1 === 1'b1);
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        nvec++; if (sent != 40) begin nerr++; $display("FAIL wrap_sent: got %0d want 40", sent); end
        drain();
    endtask

    initial begin
        rst = 1'b1; in_flit = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_fwft();
        test_full();
        test_fullpacket();
        test_packet_size();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
